// File: rtl/master_write_dma.sv
// AXI write-channel initiator for the DMA engine.
// Issues one INCR burst on AW, streams buffer beats on W, then collects B.
module master_write_dma #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int MST_ID = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    start_len,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] strb_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [LEN_W-1:0]    AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ID_W-1:0] ID_C = ID_W'(MST_ID);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RESP
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [LEN_W-1:0]    awlen_q;
  logic                awvalid_q;
  logic                aw_done_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                wlast_q;
  logic                wvalid_q;
  logic                w_done_q;
  logic [LEN_W:0]      loaded_q;
  logic                bready_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic [LEN_W:0]      beats;
  logic                load;
  logic                aw_hs;
  logic                w_hs;
  logic                w_last_hs;
  logic                aw_ok;
  logic                w_ok;
  logic                b_err;

  assign beats = {1'b0, awlen_q} + (LEN_W+1)'(1);

  // Single holding register on W: refill only when empty or draining.
  assign data_ready = (state_q == BURST)
                    && (!wvalid_q || WREADY)
                    && (loaded_q < beats);

  assign load      = data_valid && data_ready;
  assign aw_hs     = awvalid_q && AWREADY;
  assign w_hs      = wvalid_q && WREADY;
  assign w_last_hs = w_hs && wlast_q;
  assign aw_ok     = aw_done_q || aw_hs;
  assign w_ok      = w_done_q || w_last_hs;
  assign b_err     = (BRESP != 2'b00) || (BID != ID_C);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      w_done_q  <= 1'b0;
      loaded_q  <= '0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            awaddr_q  <= start_addr;
            awlen_q   <= start_len;
            awvalid_q <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wlast_q   <= 1'b0;
            loaded_q  <= '0;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (load) begin
            wdata_q  <= data_in;
            wstrb_q  <= strb_in;
            wvalid_q <= 1'b1;
            wlast_q  <= (loaded_q == {1'b0, awlen_q});
            loaded_q <= loaded_q + (LEN_W+1)'(1);
          end else if (w_hs) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
          end
          if (w_last_hs) begin
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (BVALID) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= b_err;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign AWID    = ID_C;
  assign AWADDR  = awaddr_q;
  assign AWLEN   = awlen_q;
  assign AWSIZE  = 3'($clog2(STRB_W));
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = wlast_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_master_write_dma.sv
// Bench for master_write_dma: directed and randomized bursts
// checked against a queue-based model of the expected AXI traffic.
module tb_master_write_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [3:0]  start_len = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  strb_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [3:0]  BID = '0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit last_err = 1'b0;

  master_write_dma dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .data_in    (data_in),
    .strb_in    (strb_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .AWID       (AWID),
    .AWADDR     (AWADDR),
    .AWLEN      (AWLEN),
    .AWSIZE     (AWSIZE),
    .AWBURST    (AWBURST),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .WDATA      (WDATA),
    .WSTRB      (WSTRB),
    .WLAST      (WLAST),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .BID        (BID),
    .BRESP      (BRESP),
    .BVALID     (BVALID),
    .BREADY     (BREADY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction with a simple responder and a beat-queue model.
  task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                           input int aw_dly, input int wr_pct,
                           input int dv_pct, input int stall_beat,
                           input bit seq, input logic [1:0] rsp,
                           input logic [3:0] bid, input bit glitch);
    logic [31:0] exp_d[$];
    logic [3:0]  exp_s[$];
    int src_idx = 0;
    int wcnt = 0;
    int awcnt = 0;
    int dncnt = 0;
    int aw_wait = 0;
    int stall = 0;
    int cyc = 0;
    bit b_prev = 1'b0;
    bit w_stall = 1'b0;
    bit aw_stall = 1'b0;
    bit bdone = 1'b0;
    bit hold;
    bit exp_err;
    logic [31:0] pd = '0;
    logic [3:0]  ps = '0;
    logic        pl = 1'b0;
    exp_err = (rsp != 2'b00) || (bid != 4'd0);
    for (int i = 0; i <= int'(len); i++) begin
      exp_d.push_back(seq ? 32'hA0 + 32'(i) : $urandom);
      exp_s.push_back(seq ? 4'hF : 4'($urandom_range(15)));
    end
    @(negedge clock);
    chk("err_hold", 32'(error), 32'(last_err));
    start      = 1'b1;
    start_addr = addr;
    start_len  = len;
    @(negedge clock);
    start      = 1'b0;
    start_addr = $urandom;
    start_len  = 4'($urandom_range(15));
    chk("busy_lat", 32'(busy), 32'd1);
    chk("awvalid_lat", 32'(AWVALID), 32'd1);
    while (!bdone && cyc < 400) begin
      chk("done_pulse", 32'(done), 32'(b_prev));
      if (done) dncnt++;
      if (b_prev) begin
        chk("error", 32'(error), 32'(exp_err));
        chk("busy_clr", 32'(busy), 32'd0);
        chk("bready_clr", 32'(BREADY), 32'd0);
        BVALID = 1'b0;
        bdone  = 1'b1;
      end else begin
        if (aw_stall) begin
          chk("aw_hold_v", 32'(AWVALID), 32'd1);
          chk("aw_hold_a", AWADDR, addr);
        end
        if (w_stall) begin
          chk("w_hold_v", 32'(WVALID), 32'd1);
          chk("w_hold_d", WDATA, pd);
          chk("w_hold_s", 32'(WSTRB), 32'(ps));
          chk("w_hold_l", 32'(WLAST), 32'(pl));
        end
        start = glitch && (cyc == 2);
        if (start) start_addr = addr ^ 32'h0000_FFF0;
        AWREADY = AWVALID && (aw_wait >= aw_dly);
        if (AWVALID) aw_wait++;
        hold = (wcnt == stall_beat) && (stall < 3);
        WREADY = ($urandom_range(99) < wr_pct) && !hold;
        if (hold && WVALID) stall++;
        data_valid = ($urandom_range(99) < dv_pct);
        data_in = (src_idx <= int'(len)) ? exp_d[src_idx] : $urandom;
        strb_in = (src_idx <= int'(len)) ? exp_s[src_idx]
                                         : 4'($urandom_range(15));
        if (awcnt == 1 && wcnt == int'(len) + 1) begin
          BVALID = 1'b1;
          BRESP  = rsp;
          BID    = bid;
        end
        #1;
        if (data_valid && data_ready) src_idx++;
        if (WVALID && !WREADY) chk("no_extra_ready", 32'(data_ready), 32'd0);
        if (AWVALID && AWREADY) begin
          awcnt++;
          chk("awaddr", AWADDR, addr);
          chk("awlen", 32'(AWLEN), 32'(len));
          chk("awsize", 32'(AWSIZE), 32'd2);
          chk("awburst", 32'(AWBURST), 32'd1);
          chk("awid", 32'(AWID), 32'd0);
        end
        if (WVALID && WREADY) begin
          chk("wdata", WDATA, exp_d[wcnt]);
          chk("wstrb", 32'(WSTRB), 32'(exp_s[wcnt]));
          chk("wlast", 32'(WLAST), 32'(wcnt == int'(len)));
          wcnt++;
        end
        if (BREADY)
          chk("resp_order", 32'(awcnt == 1 && wcnt == int'(len) + 1), 32'd1);
        b_prev   = BVALID && BREADY;
        aw_stall = AWVALID && !AWREADY;
        w_stall  = WVALID && !WREADY;
        pd = WDATA;
        ps = WSTRB;
        pl = WLAST;
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    data_valid = 1'b0;
    AWREADY = 1'b0;
    WREADY = 1'b0;
    chk("timeout", 32'(bdone), 32'd1);
    @(negedge clock);
    chk("done_once", 32'(done), 32'd0);
    chk("beats", 32'(wcnt), 32'(int'(len) + 1));
    chk("aw_count", 32'(awcnt), 32'd1);
    chk("done_count", 32'(dncnt), 32'd1);
    last_err = exp_err;
  endtask

  initial begin
    #1;
    chk("rst_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_wvalid", 32'(WVALID), 32'd0);
    chk("rst_bready", 32'(BREADY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_dready", 32'(data_ready), 32'd0);
    chk("rst_awaddr", AWADDR, 32'd0);
    chk("rst_wlast", 32'(WLAST), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_burst(32'h1000, 4'd3, 0, 100, 100, -1, 1'b1, 2'b00, 4'd0, 1'b0);
    run_burst(32'h2000, 4'd0, 8, 100, 100, -1, 1'b0, 2'b00, 4'd0, 1'b0);
    run_burst(32'h2100, 4'd7, 0, 100, 100, 2, 1'b0, 2'b00, 4'd0, 1'b0);
    run_burst(32'h2200, 4'd2, 1, 100, 100, -1, 1'b0, 2'b10, 4'd0, 1'b0);
    run_burst(32'h2300, 4'd1, 0, 100, 100, -1, 1'b0, 2'b00, 4'd1, 1'b0);
    run_burst(32'h4000, 4'd5, 5, 100, 100, -1, 1'b0, 2'b00, 4'd0, 1'b1);

    // Abandon a burst with an asynchronous reset between clock edges.
    @(negedge clock);
    start = 1'b1;
    start_addr = 32'h3000;
    start_len = 4'd7;
    @(negedge clock);
    start = 1'b0;
    data_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("pre_rst_awvalid", 32'(AWVALID), 32'd1);
    chk("pre_rst_wvalid", 32'(WVALID), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_awvalid", 32'(AWVALID), 32'd0);
    chk("mid_rst_wvalid", 32'(WVALID), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dready", 32'(data_ready), 32'd0);
    chk("mid_rst_bready", 32'(BREADY), 32'd0);
    @(negedge clock);
    data_valid = 1'b0;
    reset = 1'b1;
    last_err = 1'b0;
    run_burst(32'h5000, 4'd4, 2, 100, 100, -1, 1'b0, 2'b00, 4'd0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_burst({$urandom_range(32'hFFFF), 2'b00} , 4'($urandom_range(15)),
                $urandom_range(6), $urandom_range(40, 100),
                $urandom_range(40, 100), -1, 1'b0,
                ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00,
                ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'd0,
                1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
